// File: rtl/fp_add_sub_seq.sv
// fp_add_sub_seq: multi-cycle IEEE-754-style add/sub with RNE; define FP_ADD_SUB_SUBNORMAL_EN for subnormal support
module fp_add_sub_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int W = EXP_W + MAN_W + 1
) (
  input  logic         control,
  input  logic         reset,
  input  logic         start,
  input  logic         addsub,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] out,
  output logic         exception,
  output logic [3:0]   flags
);
  localparam int MW = MAN_W + 5;
  localparam int SW = MAN_W + 3;
  localparam logic [EXP_W:0] ONE = 1;
  localparam logic [EXP_W:0] TWO = 2;
  localparam logic [EXP_W:0] EMAX = {1'b0, {EXP_W{1'b1}}};
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE} state_t;
  state_t state;
  logic [W-1:0] a_q, b_q, res;
  logic [EXP_W:0] x_e, y_e, e;
  logic [MAN_W:0] x_m, y_m;
  logic x_s, y_s, sgn, sub, fin;
  logic [MW-1:0] m_a, m_b, m;
  logic [3:0] fl;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_snan, b_snan, nan_out, spec, spec_inv;
  logic [W-1:0] spec_res;
  logic [EXP_W:0] ea_eff, eb_eff;
  logic [MAN_W:0] ma, mb;
  always_comb begin
    ea = a_q[W-2:MAN_W];
    fa = a_q[MAN_W-1:0];
    eb = b_q[W-2:MAN_W];
    fb = b_q[MAN_W-1:0];
    a_nan = &ea && |fa;
    b_nan = &eb && |fb;
    a_inf = &ea && !(|fa);
    b_inf = &eb && !(|fb);
    a_snan = a_nan && !fa[MAN_W-1];
    b_snan = b_nan && !fb[MAN_W-1];
`ifdef FP_ADD_SUB_SUBNORMAL_EN
    a_zero = ea == '0 && fa == '0;
    b_zero = eb == '0 && fb == '0;
    ea_eff = ea == '0 ? ONE : {1'b0, ea};
    eb_eff = eb == '0 ? ONE : {1'b0, eb};
    ma = {|ea, fa};
    mb = {|eb, fb};
`else
    a_zero = ea == '0;
    b_zero = eb == '0;
    ea_eff = {1'b0, ea};
    eb_eff = {1'b0, eb};
    ma = a_zero ? '0 : {1'b1, fa};
    mb = b_zero ? '0 : {1'b1, fb};
`endif
    nan_out = a_nan || b_nan || (a_inf && b_inf && (a_q[W-1] != b_q[W-1]));
    spec = a_nan || b_nan || a_inf || b_inf || (a_zero && b_zero);
    spec_inv = a_snan || b_snan || (a_inf && b_inf && (a_q[W-1] != b_q[W-1]));
    spec_res = nan_out ? QNAN :
               a_inf ? {a_q[W-1], {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
               b_inf ? {b_q[W-1], {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
               {a_q[W-1] & b_q[W-1], {(W-1){1'b0}}};
  end
  logic swap, st;
  logic [EXP_W:0] e_big, e_sml;
  logic [MAN_W:0] m_big, m_sml;
  logic [SW-1:0] v, sh;
  int dn;
  always_comb begin
    swap = {y_e, y_m} > {x_e, x_m};
    e_big = swap ? y_e : x_e;
    e_sml = swap ? x_e : y_e;
    m_big = swap ? y_m : x_m;
    m_sml = swap ? x_m : y_m;
    dn = int'(e_big - e_sml);
    v = {m_sml, 2'b00};
    sh = dn >= SW ? '0 : v >> dn;
    st = dn >= SW ? |m_sml : |(v << (SW - dn));
  end
  logic [MW-1:0] sum;
  assign sum = sub ? m_a - m_b : m_a + m_b;
  logic inx, inc, ovm, rhid, ovf, tiny;
  logic [MAN_W+1:0] rm;
  logic [MAN_W-1:0] frc;
  logic [EXP_W:0] ef;
  logic [EXP_W-1:0] ex;
  logic [W-1:0] r_res, o_res;
  logic [3:0] r_fl, o_fl;
  always_comb begin
    inx = |m[2:0];
    inc = m[2] & (|m[1:0] | m[3]);
    rm = {1'b0, m[MW-2:3]} + {{(MAN_W+1){1'b0}}, inc};
    ovm = rm[MAN_W+1];
    frc = ovm ? rm[MAN_W:1] : rm[MAN_W-1:0];
    rhid = ovm | rm[MAN_W];
    ef = e + {{EXP_W{1'b0}}, ovm};
    ex = rhid ? ef[EXP_W-1:0] : '0;
    ovf = ef >= EMAX;
    tiny = !m[MW-2];
`ifdef FP_ADD_SUB_SUBNORMAL_EN
    r_res = ovf ? {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}} : {sgn, ex, frc};
    r_fl = ovf ? 4'b0101 : {2'b00, tiny & inx, inx};
`else
    r_res = ovf ? {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}} : tiny ? {sgn, {(W-1){1'b0}}} : {sgn, ex, frc};
    r_fl = ovf ? 4'b0101 : tiny ? 4'b0011 : {3'b000, inx};
`endif
    o_res = fin ? res : r_res;
    o_fl = fin ? fl : r_fl;
  end
  always_ff @(posedge control) begin
    if (reset) begin
      state <= IDLE;
      out <= '0;
      flags <= '0;
      exception <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          a_q <= A;
          b_q <= {B[W-1] ^ addsub, B[W-2:0]};
          busy <= 1'b1;
          state <= UNPACK;
        end
        UNPACK: begin
          x_e <= ea_eff;
          y_e <= eb_eff;
          x_m <= ma;
          y_m <= mb;
          x_s <= a_q[W-1];
          y_s <= b_q[W-1];
          fin <= spec;
          res <= spec_res;
          fl <= {spec_inv, 3'b000};
          state <= spec ? ROUND : ALIGN;
        end
        ALIGN: begin
          e <= e_big;
          m_a <= {1'b0, m_big, 3'b000};
          m_b <= {1'b0, sh, st};
          sgn <= swap ? y_s : x_s;
          sub <= x_s ^ y_s;
          state <= ADD;
        end
        ADD: begin
          m <= sum;
          if (sum == '0) begin
            fin <= 1'b1;
            res <= '0;
            fl <= '0;
            state <= ROUND;
          end else state <= NORM;
        end
        NORM: begin
          // Left shifts look one bit ahead so k shifts take exactly k cycles
          if (m[MW-1]) begin
            m <= {1'b0, m[MW-1:2], m[1] | m[0]};
            e <= e + ONE;
            state <= ROUND;
          end else if (m[MW-2] || e <= ONE) state <= ROUND;
          else begin
            m <= m << 1;
            e <= e - ONE;
            if (m[MW-3] || e == TWO) state <= ROUND;
          end
        end
        ROUND: begin
          out <= o_res;
          flags <= o_fl;
          exception <= o_fl[3] | o_fl[2];
          done <= 1'b1;
          busy <= 1'b0;
          state <= DONE;
        end
        DONE: begin
          done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_add_sub_seq.sv
// tb_fp_add_sub_seq: table-driven vectors with a scoreboard queue, plus abort and ignored-start sequences
module tb_fp_add_sub_seq;
  logic control = 1'b0, reset = 1'b1, start = 1'b0, addsub = 1'b0;
  logic [31:0] A = '0, B = '0, out;
  logic busy, done, exception;
  logic [3:0] flags;
  int vectors = 0, miscompares = 0, checks = 0;
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic op;
    logic [31:0] r;
    logic [3:0] f;
    int lat;
  } vec_t;
  typedef struct {
    logic [31:0] r;
    logic [3:0] f;
    int lat;
  } exp_t;
  vec_t tbl[$];
  exp_t sbq[$];
  fp_add_sub_seq dut (
    .control(control), .reset(reset), .start(start), .addsub(addsub),
    .A(A), .B(B), .busy(busy), .done(done), .out(out),
    .exception(exception), .flags(flags)
  );
  always #5 control = ~control;
  initial begin
    #500000;
    $display("FAIL global timeout");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask
  task automatic t(input logic [31:0] a, b, input logic op, input logic [31:0] r, input logic [3:0] f, input int lat);
    tbl.push_back('{a, b, op, r, f, lat});
  endtask
  task automatic issue(input logic [31:0] a, b, input logic op, input logic [31:0] r, input logic [3:0] f, input int lat);
    A = a;
    B = b;
    addsub = op;
    start = 1'b1;
    sbq.push_back('{r, f, lat});
    vectors++;
    @(posedge control);
    #1 start = 1'b0;
  endtask
  // poke: 1 = extra start while busy, 2 = extra start during the done cycle
  task automatic collect(input string nm, input int poke);
    int lat = 1;
    bit busy_ok = 1;
    exp_t e;
    while (!done && lat < 100) begin
      if (poke == 1 && lat == 3) begin
        A = 32'h3F800000;
        B = 32'h3F800000;
        addsub = 1'b0;
        start = 1'b1;
      end
      @(posedge control);
      #1 start = 1'b0;
      lat++;
      if (!done && !busy) busy_ok = 0;
    end
    if (!done) begin
      miscompares++;
      $display("FAIL %s: no done within %0d cycles", nm, lat);
      if (sbq.size() != 0) e = sbq.pop_front();
      return;
    end
    if (sbq.size() == 0) begin
      miscompares++;
      $display("FAIL %s: done with empty scoreboard", nm);
      return;
    end
    e = sbq.pop_front();
    chk({nm, " out"}, out, e.r);
    chk({nm, " flags"}, 32'(flags), 32'(e.f));
    chk({nm, " exception"}, 32'(exception), 32'(e.f[3] | e.f[2]));
    chk({nm, " busy at done"}, 32'(busy), 32'd0);
    chk({nm, " busy while running"}, 32'(busy_ok), 32'd1);
    if (e.lat != 0) chk({nm, " latency"}, 32'(lat), 32'(e.lat));
    if (poke == 2) begin
      A = 32'h7F800000;
      B = 32'h3F800000;
      addsub = 1'b0;
      start = 1'b1;
    end
    @(posedge control);
    #1 start = 1'b0;
    chk({nm, " done pulse width"}, 32'(done), 32'd0);
    chk({nm, " out held"}, out, e.r);
    if (poke == 2) begin
      repeat (3) begin
        @(posedge control);
        #1;
      end
      chk({nm, " start in done ignored"}, 32'(busy), 32'd0);
      chk({nm, " out held after ignored start"}, out, e.r);
    end
  endtask
  initial begin
    exp_t dropped;
    bit saw;
    t(32'h3F800000, 32'h3F800000, 0, 32'h40000000, 4'h0, 6);
    t(32'h3FC00000, 32'h3F800000, 1, 32'h3F000000, 4'h0, 6);
    t(32'h3F800000, 32'h3F800000, 1, 32'h00000000, 4'h0, 0);
    t(32'h3F800000, 32'h33800000, 0, 32'h3F800000, 4'h1, 6);
    t(32'h3F800000, 32'h33C00000, 0, 32'h3F800001, 4'h1, 6);
    t(32'h7F7FFFFF, 32'h7F7FFFFF, 0, 32'h7F800000, 4'h5, 6);
    t(32'h7F800000, 32'h7F800000, 1, 32'h7FC00000, 4'h8, 3);
    t(32'h7FC00000, 32'h3F800000, 0, 32'h7FC00000, 4'h0, 3);
    t(32'h7F800001, 32'h3F800000, 0, 32'h7FC00000, 4'h8, 3);
    t(32'h3F800000, 32'h7F800000, 1, 32'hFF800000, 4'h0, 3);
    t(32'h7F800000, 32'h7F800000, 0, 32'h7F800000, 4'h0, 3);
    t(32'hFF800000, 32'h3F800000, 0, 32'hFF800000, 4'h0, 3);
    t(32'h80000000, 32'h00000000, 1, 32'h80000000, 4'h0, 3);
    t(32'h00000000, 32'h80000000, 0, 32'h00000000, 4'h0, 3);
    t(32'h40000000, 32'h40400000, 1, 32'hBF800000, 4'h0, 6);
    t(32'h3F800000, 32'h33000000, 1, 32'h3F800000, 4'h1, 6);
    t(32'h3F800000, 32'h30800000, 0, 32'h3F800000, 4'h1, 6);
    t(32'h00C00000, 32'h00800000, 1, 32'h00000000, 4'h3, 6);
    t(32'h3F800000, 32'hBF800000, 0, 32'h00000000, 4'h0, 0);
    repeat (3) @(posedge control);
    #1;
    chk("reset out", out, 32'h0);
    chk("reset flags", 32'(flags), 32'h0);
    chk("reset exception", 32'(exception), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset done", 32'(done), 32'h0);
    reset = 1'b0;
    @(posedge control);
    #1;
    foreach (tbl[i]) begin
      issue(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].r, tbl[i].f, tbl[i].lat);
      collect($sformatf("v%0d", i), i == 0 ? 2 : 0);
    end
    issue(32'h3F800001, 32'h3F800000, 1, 32'h34000000, 4'h0, 28);
    collect("start_while_busy", 1);
    issue(32'h3F800001, 32'h3F800000, 1, 32'h34000000, 4'h0, 28);
    repeat (4) begin
      @(posedge control);
      #1;
    end
    reset = 1'b1;
    @(posedge control);
    #1 reset = 1'b0;
    dropped = sbq.pop_front();
    chk("abort out", out, 32'h0);
    chk("abort flags", 32'(flags), 32'h0);
    chk("abort exception", 32'(exception), 32'h0);
    chk("abort busy", 32'(busy), 32'h0);
    chk("abort done", 32'(done), 32'h0);
    saw = 0;
    repeat (30) begin
      @(posedge control);
      #1;
      if (done) saw = 1;
    end
    chk("no done after abort", 32'(saw), 32'h0);
    issue(32'h3F800001, 32'h3F800000, 1, 32'h34000000, 4'h0, 28);
    collect("after_abort", 0);
    chk("scoreboard drained", 32'(sbq.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
